// File: rtl/bool_sweep_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : bool_sweep_pkg                                                |
// | Purpose : Shared types and sizing helpers for the Boolean-function      |
// |           sweep controller (FSM state encoding, truth-table width).     |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
package bool_sweep_pkg;

  localparam int N_IN_DEF = 3;

  // One truth-table bit per input vector.
  function automatic int tt_width(input int n_in);
    return 2 ** n_in;
  endfunction

  localparam int TT_W_DEF = tt_width(N_IN_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

endpackage
`default_nettype wire

// File: rtl/sweep_settle_cnt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sweep_settle_cnt                                              |
// | Purpose : Loadable down-counter timing the settle window of each sweep  |
// |           vector. Expiry is flagged when the count reaches zero.        |
// | Ports   : clk, rst      - clock, synchronous active-high reset          |
// |           clr           - synchronous clear to zero                     |
// |           load/load_val - load a new start count                        |
// |           dec           - decrement (saturates at zero)                 |
// |           expired       - count is zero                                 |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module sweep_settle_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/bool_func_sweep_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : bool_func_sweep_ctrl                                          |
// | Purpose : Sweeps all 2^N_IN input vectors of a combinational Boolean    |
// |           function, holds each for SETTLE_CYC cycles, captures d_in     |
// |           into a truth table and compares it to a latched expected one. |
// | Ports   : clk, rst  - clock, synchronous active-high reset              |
// |           start     - begin a sweep (accepted in IDLE only)             |
// |           abort     - cancel a sweep, back to IDLE with no done         |
// |           exp_tt    - expected truth table, latched at start            |
// |           d_in      - output of the function under test                 |
// |           vec_out   - function inputs (a=[2], b=[1], c=[0])             |
// |           busy      - sweep in progress                                 |
// |           done      - one-cycle completion pulse                        |
// |           pass      - captured table matched expected (valid with done) |
// |           tt_out    - captured truth table                              |
// | Option  : SWEEP_FIRST_FAIL_EN adds first_fail_idx / fail_seen ports     |
// |           reporting the lowest mismatching vector of the sweep.         |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module bool_func_sweep_ctrl
  import bool_sweep_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [tt_width(N_IN)-1:0] exp_tt,
  input  logic                      d_in,
  output logic [N_IN-1:0]           vec_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [tt_width(N_IN)-1:0] tt_out
`ifdef SWEEP_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]           first_fail_idx,
  output logic                      fail_seen
`endif
);

  localparam int TT_W  = tt_width(N_IN);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  // The counter starts at SETTLE_CYC-1 and SETTLE advances on expiry,
  // which gives exactly SETTLE_CYC cycles in SETTLE per vector.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  IDX_LAST    = '1;

  sweep_state_e    state;
  sweep_state_e    state_next;

  logic [N_IN-1:0] idx;
  logic [TT_W-1:0] exp_lat;
  logic [TT_W-1:0] tt_cap;
  logic            accept;
  logic            capture;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_clr;
  logic            cnt_expired;
  logic            last_vec;

  // --------------------------------------------------------------------
  // Settle timer
  // --------------------------------------------------------------------
  sweep_settle_cnt #(
    .W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .expired  (cnt_expired)
  );

  // --------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign last_vec = (idx == IDX_LAST);
  assign cnt_clr  = abort && (state != IDLE);

  // --------------------------------------------------------------------
  // FSM: next state and control strobes
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        // abort dominates a simultaneous start
        if (start && !abort) begin
          accept     = 1'b1;
          cnt_load   = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt_expired) begin
          state_next = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          capture = 1'b1;
          if (last_vec) begin
            state_next = DONE;
          end else begin
            cnt_load   = 1'b1;
            state_next = SETTLE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state == SETTLE) || (state == SAMPLE);
  assign done    = (state == DONE);
  // The index register drives the function directly; it is only updated
  // at sweep start and after each sample, so it holds in DONE/IDLE.
  assign vec_out = idx;

  // Truth table including the bit being sampled this cycle, so pass can be
  // registered on the same edge that enters DONE and be valid with done.
  always_comb begin
    tt_cap      = tt_out;
    tt_cap[idx] = d_in;
  end

  // --------------------------------------------------------------------
  // Index, truth-table capture and verdict
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      exp_lat <= '0;
      tt_out  <= '0;
      pass    <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      exp_lat <= exp_tt;
      tt_out  <= '0;
      pass    <= 1'b0;
    end else if (capture) begin
      tt_out <= tt_cap;
      if (last_vec) begin
        pass <= (tt_cap == exp_lat);
      end else begin
        idx <= idx + N_IN'(1);
      end
    end
  end

`ifdef SWEEP_FIRST_FAIL_EN
  // Lowest mismatching vector of the current sweep; vectors are sampled in
  // ascending order so the first recorded mismatch is the lowest one.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
    end else if (accept) begin
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
    end else if (capture && !fail_seen && (d_in != exp_lat[idx])) begin
      first_fail_idx <= idx;
      fail_seen      <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bool_func_sweep_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_bool_func_sweep_ctrl                                       |
// | Purpose : Scoreboard testbench for bool_func_sweep_ctrl. The function   |
// |           under test is a random truth table looked up by vec_out; the  |
// |           expected sweep result is derived from that table directly.    |
// | Option  : SWEEP_FIRST_FAIL_EN enables first-fail port checks.           |
// | Revision: 1.0 - initial release                                         |
// +------------------------------------------------------------------------+
module tb_bool_func_sweep_ctrl;

  localparam int N_IN       = 3;
  localparam int SETTLE_CYC = 2;
  localparam int TT_W       = 1 << N_IN;
  localparam int STEP       = SETTLE_CYC + 1;
  localparam int LAT        = TT_W * STEP;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            abort;
  logic            d_in;
  logic [TT_W-1:0] exp_tt;
  logic [TT_W-1:0] tt_out;
  logic [TT_W-1:0] fn_tt;
  logic [N_IN-1:0] vec_out;
  logic            busy;
  logic            done;
  logic            pass;
`ifdef SWEEP_FIRST_FAIL_EN
  logic [N_IN-1:0] first_fail_idx;
  logic            fail_seen;
`endif

  bool_func_sweep_ctrl #(
    .N_IN       (N_IN),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .exp_tt  (exp_tt),
    .d_in    (d_in),
    .vec_out (vec_out),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .tt_out  (tt_out)
`ifdef SWEEP_FIRST_FAIL_EN
    ,
    .first_fail_idx (first_fail_idx),
    .fail_seen      (fail_seen)
`endif
  );

  always #5 clk = ~clk;

  // Function under test: a truth-table lookup on the driven vector.
  assign d_in = fn_tt[vec_out];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              acc;
    logic [TT_W-1:0] tt;
    logic            pass;
    logic [N_IN-1:0] ff_idx;
    logic            ff_seen;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [TT_W-1:0] f, input logic [TT_W-1:0] e,
                                 input int acc);
    exp_t r;
    r.acc     = acc;
    r.tt      = f;
    r.pass    = (f == e);
    r.ff_seen = 1'b0;
    r.ff_idx  = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (f[i] != e[i]) begin
        r.ff_seen = 1'b1;
        r.ff_idx  = N_IN'(i);
      end
    end
    return r;
  endfunction

  // ------------------------------------------------------------------
  // Monitor: per-cycle sweep checks and done/result scoreboard
  // ------------------------------------------------------------------
  always @(negedge clk) begin
    int   t;
    exp_t r;
    if (!rst && q.size() > 0) begin
      t = cyc - q[0].acc;
      if (t >= 0 && t < LAT) begin
        chk("vec_out", 64'(vec_out), 64'(t / STEP));
        chk("busy", 64'(busy), 64'd1);
        chk("done_early", 64'(done), 64'd0);
      end
    end
    if (!rst && done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        r = q.pop_front();
        chk("done_latency", 64'(cyc - r.acc), 64'(LAT));
        chk("tt_out", 64'(tt_out), 64'(r.tt));
        chk("pass", 64'(pass), 64'(r.pass));
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("vec_out_at_done", 64'(vec_out), 64'(TT_W - 1));
`ifdef SWEEP_FIRST_FAIL_EN
        chk("fail_seen", 64'(fail_seen), 64'(r.ff_seen));
        if (r.ff_seen) chk("first_fail_idx", 64'(first_fail_idx), 64'(r.ff_idx));
`endif
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  // Returns at the negedge right after the accepting edge (t = 0).
  task automatic launch(input logic [TT_W-1:0] f, input logic [TT_W-1:0] e,
                        input bit expect_run);
    @(negedge clk);
    fn_tt  = f;
    exp_tt = e;
    start  = 1'b1;
    if (expect_run) q.push_back(model(f, e, cyc + 1));
    @(negedge clk);
    start  = 1'b0;
    exp_tt = TT_W'($urandom);  // must not affect the running sweep
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (q.size() > 0 && i < LAT + 20) begin
      @(negedge clk);
      i++;
    end
    if (q.size() > 0) begin
      chk("sweep_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle_watch(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vec_out"}, 64'(vec_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_tt_out"}, 64'(tt_out), 64'd0);
`ifdef SWEEP_FIRST_FAIL_EN
    chk({tag, "_fail_seen"}, 64'(fail_seen), 64'd0);
    chk({tag, "_ff_idx"}, 64'(first_fail_idx), 64'd0);
`endif
  endtask

  task automatic abort_run(input logic [TT_W-1:0] f, input int t_ab);
    logic [TT_W-1:0] part;
    int              ncap;
    launch(f, TT_W'($urandom), 1'b0);
    repeat (t_ab) @(negedge clk);
    chk("busy_before_abort", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    // Vectors whose sample edge fell before the aborting edge are kept.
    ncap = t_ab / STEP;
    part = '0;
    for (int i = 0; i < TT_W; i++) if (i < ncap) part[i] = f[i];
    chk("busy_after_abort", 64'(busy), 64'd0);
    chk("done_after_abort", 64'(done), 64'd0);
    chk("tt_after_abort", 64'(tt_out), 64'(part));
    chk("pass_after_abort", 64'(pass), 64'd0);
    idle_watch(LAT + 6);
    chk("tt_hold_after_abort", 64'(tt_out), 64'(part));
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    logic [TT_W-1:0] f_aoc;
    logic [TT_W-1:0] f;
    logic [TT_W-1:0] e;
    int              a_in, b_in, c_in;

    rst    = 1'b1;
    start  = 1'b1;   // must be ignored while in reset
    abort  = 1'b0;
    exp_tt = '1;
    fn_tt  = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // d = a&b | c
    for (int i = 0; i < TT_W; i++) begin
      a_in     = (i >> 2) & 1;
      b_in     = (i >> 1) & 1;
      c_in     = i & 1;
      f_aoc[i] = ((a_in & b_in) | c_in) != 0;
    end
    launch(f_aoc, 8'hEA, 1'b1);
    wait_idle();
    idle_watch(3);
    chk("tt_hold", 64'(tt_out), 64'(f_aoc));
    chk("pass_hold", 64'(pass), 64'd1);

    launch(f_aoc, 8'hEB, 1'b1);
    wait_idle();

    // abort at cycle 10, then a clean sweep
    abort_run(TT_W'($urandom), 10);
    launch(f_aoc, 8'hEA, 1'b1);
    wait_idle();

    // start re-pulsed mid sweep
    f = TT_W'($urandom);
    launch(f, f, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; exp_tt = TT_W'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1; exp_tt = TT_W'($urandom);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    idle_watch(LAT);

    // reset mid sweep
    launch(TT_W'($urandom), TT_W'($urandom), 1'b1);
    repeat (15) @(negedge clk);
    rst   = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    q.delete();
    @(negedge clk);
    rst   = 1'b0;
    check_zero("mid_reset");
    // start and abort together in IDLE: stays idle
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    idle_watch(LAT + 4);
    chk("start_abort_idle", 64'(busy), 64'd0);

    // randomized sweeps and aborts
    for (int n = 0; n < 20; n++) begin
      f = TT_W'($urandom);
      e = ($urandom_range(0, 1) == 0) ? f : TT_W'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        abort_run(f, $urandom_range(1, LAT - 1));
      end else begin
        launch(f, e, 1'b1);
        wait_idle();
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
